compass_sequencer: RTL and testbench



---
 rtl/compass_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_compass_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/compass_sequencer.sv
// Plays a programmed sequence of 2-bit compass directions onto a valid/ready
// stream, with optional repeat passes and idle gaps between accepted symbols.
module compass_sequencer #(
  parameter int MAX_LEN    = 8,
  parameter int GAP_CYCLES = 0,
  parameter int REP_W      = 4,
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [2*MAX_LEN-1:0]   pattern_i,
  input  logic [LEN_W-1:0]       length_i,
  input  logic [REP_W-1:0]       repeat_i,
  input  logic                   abort_i,
  input  logic                   ready_i,
  output logic [1:0]             direction_o,
  output logic                   valid_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic [REP_W-1:0]       pass_q, pass_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [2*MAX_LEN-1:0]   pattern_q, pattern_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [REP_W-1:0]       rep_q, rep_d;
  logic [1:0]             dir_q, dir_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   handshake_s;
  logic                   last_idx_s;
  logic                   last_pass_s;
  logic                   final_xfer_s;

  function automatic logic [1:0] sym_at(input logic [2*MAX_LEN-1:0] pat,
                                        input logic [LEN_W-1:0]     idx);
    logic [1:0] s;
    s = 2'b00;
    for (int k = 0; k < MAX_LEN; k++) begin
      s = (idx == LEN_W'(k)) ? pat[2*k +: 2] : s;
    end
    return s;
  endfunction

  assign handshake_s  = valid_q & ready_i;
  assign last_idx_s   = (idx_q == (len_q - LEN_W'(1)));
  assign last_pass_s  = (pass_q == rep_q);
  assign final_xfer_s = handshake_s & last_idx_s & last_pass_s;

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    gap_d     = gap_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    rep_d     = rep_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          pattern_d = pattern_i;
          rep_d     = repeat_i;
          idx_d     = {LEN_W{1'b0}};
          pass_d    = {REP_W{1'b0}};
          gap_d     = {GAP_W{1'b0}};
          if (length_i == {LEN_W{1'b0}}) begin
            len_d   = {LEN_W{1'b0}};
            state_d = DONE;
          end else if (length_i > LEN_W'(MAX_LEN)) begin
            len_d   = LEN_W'(MAX_LEN);
            state_d = SEND;
          end else begin
            len_d   = length_i;
            state_d = SEND;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SEND: begin
        // Pass is compared before it increments, so an all-ones repeat never wraps.
        if (handshake_s && !final_xfer_s) begin
          if (last_idx_s) begin
            idx_d  = {LEN_W{1'b0}};
            pass_d = pass_q + REP_W'(1);
          end else begin
            idx_d  = idx_q + LEN_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end

        if (abort_i) begin
          state_d = IDLE;
        end else if (final_xfer_s) begin
          state_d = DONE;
        end else if (handshake_s && (GAP_CYCLES > 0)) begin
          state_d = GAP;
          gap_d   = GAP_W'(GAP_CYCLES);
        end else begin
          state_d = SEND;
        end
      end

      GAP: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (gap_q <= GAP_W'(1)) begin
          state_d = SEND;
          gap_d   = {GAP_W{1'b0}};
        end else begin
          gap_d   = gap_q - GAP_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    valid_d = (state_d == SEND);
    dir_d   = valid_d ? sym_at(pattern_d, idx_d) : 2'b00;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // State, counters, captured run configuration and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      idx_q     <= {LEN_W{1'b0}};
      pass_q    <= {REP_W{1'b0}};
      gap_q     <= {GAP_W{1'b0}};
      pattern_q <= {(2*MAX_LEN){1'b0}};
      len_q     <= {LEN_W{1'b0}};
      rep_q     <= {REP_W{1'b0}};
      dir_q     <= 2'b00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      gap_q     <= gap_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      dir_q     <= dir_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign direction_o = dir_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_compass_sequencer.sv
// Directed bench for compass_sequencer: one instance without gaps, one with
// GAP_CYCLES=2; outputs are sampled 1 time unit after each rising edge.
module tb_compass_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [15:0] pattern = 16'h0000;
  logic [3:0]  length = 4'd0;
  logic [3:0]  rep = 4'd0;
  logic        abort = 1'b0;
  logic        ready = 1'b0;

  logic [1:0]  dir0, dir1;
  logic        valid0, valid1, busy0, busy1, done0, done1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  compass_sequencer #(.MAX_LEN(8), .GAP_CYCLES(0), .REP_W(4)) u_dut (
    .clk_i(clk), .reset_i(reset), .start_i(start0), .pattern_i(pattern),
    .length_i(length), .repeat_i(rep), .abort_i(abort), .ready_i(ready),
    .direction_o(dir0), .valid_o(valid0), .busy_o(busy0), .done_o(done0)
  );

  compass_sequencer #(.MAX_LEN(8), .GAP_CYCLES(2), .REP_W(4)) u_gap (
    .clk_i(clk), .reset_i(reset), .start_i(start1), .pattern_i(pattern),
    .length_i(length), .repeat_i(rep), .abort_i(abort), .ready_i(ready),
    .direction_o(dir1), .valid_o(valid1), .busy_o(busy1), .done_o(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic obs0(input string tag, input logic [1:0] edir, input logic ev,
                      input logic eb, input logic ed);
    chk({tag, ".dir"},   {30'd0, dir0},   {30'd0, edir});
    chk({tag, ".valid"}, {31'd0, valid0}, {31'd0, ev});
    chk({tag, ".busy"},  {31'd0, busy0},  {31'd0, eb});
    chk({tag, ".done"},  {31'd0, done0},  {31'd0, ed});
  endtask

  task automatic obs1(input string tag, input logic [1:0] edir, input logic ev,
                      input logic eb, input logic ed);
    chk({tag, ".dir"},   {30'd0, dir1},   {30'd0, edir});
    chk({tag, ".valid"}, {31'd0, valid1}, {31'd0, ev});
    chk({tag, ".busy"},  {31'd0, busy1},  {31'd0, eb});
    chk({tag, ".done"},  {31'd0, done1},  {31'd0, ed});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state while reset is held
    #3;
    obs0("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    obs1("reset_gap", 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycle();
    obs0("post_reset", 2'b00, 1'b0, 1'b0, 1'b0);

    // Basic pass: symbols 11, 01
    pattern = 16'h0007; length = 4'd2; rep = 4'd0; ready = 1'b1; start0 = 1'b1;
    cycle(); start0 = 1'b0;
    obs0("basic.s0", 2'b11, 1'b1, 1'b1, 1'b0);
    cycle();
    obs0("basic.s1", 2'b01, 1'b1, 1'b1, 1'b0);
    cycle();
    obs0("basic.done", 2'b00, 1'b0, 1'b1, 1'b1);
    cycle();
    obs0("basic.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Backpressure: 11 held four cycles
    ready = 1'b0; start0 = 1'b1;
    cycle(); start0 = 1'b0;
    obs0("bp.hold0", 2'b11, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 4; k++) begin
      cycle();
      obs0("bp.hold", 2'b11, 1'b1, 1'b1, 1'b0);
    end
    ready = 1'b1;
    cycle();
    obs0("bp.s1", 2'b01, 1'b1, 1'b1, 1'b0);
    cycle();
    obs0("bp.done", 2'b00, 1'b0, 1'b1, 1'b1);
    cycle();
    obs0("bp.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Repeat and wrap: 00,01,10,11 three times
    pattern = 16'h00E4; length = 4'd4; rep = 4'd2; start0 = 1'b1;
    cycle(); start0 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      obs0("rep.sym", 2'(k % 4), 1'b1, 1'b1, 1'b0);
      cycle();
    end
    obs0("rep.done", 2'b00, 1'b0, 1'b1, 1'b1);
    cycle();
    obs0("rep.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Gap instance: 11,10,01 each followed by two idle cycles except the last
    pattern = 16'h001B; length = 4'd3; rep = 4'd0; start1 = 1'b1;
    cycle(); start1 = 1'b0;
    obs1("gap.s0", 2'b11, 1'b1, 1'b1, 1'b0);
    cycle(); obs1("gap.g0a", 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(); obs1("gap.g0b", 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(); obs1("gap.s1", 2'b10, 1'b1, 1'b1, 1'b0);
    cycle(); obs1("gap.g1a", 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(); obs1("gap.g1b", 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(); obs1("gap.s2", 2'b01, 1'b1, 1'b1, 1'b0);
    cycle(); obs1("gap.done", 2'b00, 1'b0, 1'b1, 1'b1);
    cycle(); obs1("gap.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Zero length: done next cycle, never valid
    length = 4'd0; start0 = 1'b1;
    cycle(); start0 = 1'b0;
    obs0("len0.done", 2'b00, 1'b0, 1'b1, 1'b1);
    cycle();
    obs0("len0.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Length 15 clamps to 8; start mid-run is ignored
    pattern = 16'h1B1B; length = 4'd15; rep = 4'd0; start0 = 1'b1;
    cycle(); start0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      obs0("clamp.sym", pattern[2*k +: 2], 1'b1, 1'b1, 1'b0);
      if (k == 3) start0 = 1'b1;
      if (k == 5) start0 = 1'b0;
      cycle();
    end
    obs0("clamp.done", 2'b00, 1'b0, 1'b1, 1'b1);
    cycle();
    obs0("clamp.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Abort during the stalled second symbol
    pattern = 16'h00E4; length = 4'd4; rep = 4'd0; ready = 1'b1; start0 = 1'b1;
    cycle(); start0 = 1'b0;
    obs0("abort.s0", 2'b00, 1'b1, 1'b1, 1'b0);
    cycle();
    obs0("abort.s1", 2'b01, 1'b1, 1'b1, 1'b0);
    ready = 1'b0;
    cycle();
    obs0("abort.stall", 2'b01, 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    cycle(); abort = 1'b0;
    obs0("abort.idle", 2'b00, 1'b0, 1'b0, 1'b0);
    cycle();
    obs0("abort.nodone", 2'b00, 1'b0, 1'b0, 1'b0);

    // Async reset mid-SEND takes effect before the next edge
    ready = 1'b1; start0 = 1'b1;
    cycle(); start0 = 1'b0;
    cycle();
    obs0("areset.pre", 2'b01, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("areset.valid", {31'd0, valid0}, 32'd0);
    chk("areset.busy",  {31'd0, busy0},  32'd0);
    chk("areset.dir",   {30'd0, dir0},   32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycle();
    obs0("areset.noresume", 2'b00, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
